// File: rtl/artificial_neuron.sv
// artificial_neuron
//   Three-input fixed-point neuron computing y = sat8(W1*x1 + W2*x2 + W3*x3 + BIAS).
//   Each weight product uses a Mitchell approximate logarithmic multiplier in
//   sign-magnitude form. The bias is added exactly. The result is clipped to
//   signed 8 bits.
//
//   The pipeline has two stages and no back-pressure:
//     stage 1 registers the three products together with in_valid
//     stage 2 registers the saturated sum into y
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  x1..x3 valid this cycle
//   x1..x3     in   8  signed inputs (two's complement)
//   out_valid  out  1  y valid this cycle
//   y          out  8  signed saturated neuron output
module artificial_neuron #(
  parameter logic signed [7:0] W1   = 8'sd48,
  parameter logic signed [7:0] W2   = -8'sd20,
  parameter logic signed [7:0] W3   = 8'sd36,
  parameter logic signed [7:0] BIAS = 8'sd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic signed [7:0] x1,
  input  logic signed [7:0] x2,
  input  logic signed [7:0] x3,
  output logic              out_valid,
  output logic signed [7:0] y
);

  // Mitchell multiply of two signed 8-bit operands.
  // Each magnitude m is written as 2^k * (1 + f), where f is an exact 7-bit fraction.
  // The fractions are added in 1.7 format. Bit 7 of that sum is the "s >= 1" carry.
  // Because f is exact, the shifted mantissa never has nonzero bits below the
  // binary point. Dropping the low 7 bits therefore matches truncation toward zero.
  function automatic logic signed [15:0] mitchellMul(
    input logic signed [7:0] a,
    input logic signed [7:0] w
  );
    logic [7:0]  ma;
    logic [7:0]  mw;
    logic [2:0]  ka;
    logic [2:0]  kb;
    logic [6:0]  fa;
    logic [6:0]  fb;
    logic [7:0]  s;
    logic [3:0]  ksum;
    logic [23:0] p;
    logic [15:0] mag;
    logic        neg;
    // -(-128) wraps to 8'h80, which is the unsigned magnitude 128.
    ma  = a[7] ? 8'(-a) : 8'(a);
    mw  = w[7] ? 8'(-w) : 8'(w);
    neg = a[7] ^ w[7];
    ka  = '0;
    kb  = '0;
    for (int i = 0; i < 8; i++) begin
      if (ma[i]) ka = 3'(i);
      if (mw[i]) kb = 3'(i);
    end
    // Normalising the leading one up to bit 7 leaves the fraction in bits 6:0.
    fa   = 7'(ma << (3'd7 - ka));
    fb   = 7'(mw << (3'd7 - kb));
    s    = {1'b0, fa} + {1'b0, fb};
    ksum = {1'b0, ka} + {1'b0, kb};
    if (!s[7]) p = {16'd0, 1'b1, s[6:0]} << ksum;
    else       p = {16'd0, s} << (ksum + 4'd1);
    mag = 16'(p >> 7);
    if (ma == 8'd0 || mw == 8'd0) return 16'sd0;
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  logic signed [15:0] w_p1;
  logic signed [15:0] w_p2;
  logic signed [15:0] w_p3;
  logic signed [17:0] w_sum;
  logic signed [7:0]  w_sat;

  logic signed [15:0] r_p1;
  logic signed [15:0] r_p2;
  logic signed [15:0] r_p3;
  logic               r_v1;
  logic signed [7:0]  r_y;
  logic               r_outValid;

  assign w_p1 = mitchellMul(x1, W1);
  assign w_p2 = mitchellMul(x2, W2);
  assign w_p3 = mitchellMul(x3, W3);

  // The sum is 18 bits wide. Three products of at most 2^14 in magnitude plus
  // the bias cannot overflow that width.
  assign w_sum = {{2{r_p1[15]}}, r_p1} + {{2{r_p2[15]}}, r_p2}
               + {{2{r_p3[15]}}, r_p3} + {{10{BIAS[7]}}, BIAS};

  always_comb begin
    w_sat = w_sum[7:0];
    if (w_sum > 18'sd127)       w_sat = 8'sd127;
    else if (w_sum < -18'sd128) w_sat = -8'sd128;
  end

  // Stage 1 keeps computing on invalid cycles. Only the valid bit gates the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1 <= '0;
      r_p2 <= '0;
      r_p3 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_p1 <= w_p1;
      r_p2 <= w_p2;
      r_p3 <= w_p3;
      r_v1 <= in_valid;
    end
  end

  // y is load-enabled by the stage-1 valid, so it holds the last valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y        <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= r_v1;
      if (r_v1) r_y <= w_sat;
    end
  end

  assign y         = r_y;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_artificial_neuron.sv
// tb_artificial_neuron
//   Directed and short random stimulus for artificial_neuron with its default
//   weights. Expected outputs are either hand-computed constants or come from
//   an integer-arithmetic model of the Mitchell product.
module tb_artificial_neuron;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic signed [7:0] x1;
  logic signed [7:0] x2;
  logic signed [7:0] x3;
  logic              out_valid;
  logic signed [7:0] y;

  int assertions = 0;
  int failures   = 0;

  artificial_neuron dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .out_valid (out_valid),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The Mitchell product is written as integers.
  // With m = 2^k + r, the approximation is 2^(ka+kb) + ra*2^kb + rb*2^ka
  // when the fraction sum is below one. Otherwise it is twice the cross terms.
  function automatic int refMul(input int a, input int w);
    int ma, mw, ka, kb, ra, rb, t, p;
    ma = (a < 0) ? -a : a;
    mw = (w < 0) ? -w : w;
    if (ma == 0 || mw == 0) return 0;
    ka = 0;
    while ((1 << (ka + 1)) <= ma) ka++;
    kb = 0;
    while ((1 << (kb + 1)) <= mw) kb++;
    ra = ma - (1 << ka);
    rb = mw - (1 << kb);
    t  = (ra << kb) + (rb << ka);
    if (t < (1 << (ka + kb))) p = (1 << (ka + kb)) + t;
    else                      p = 2 * t;
    return ((a < 0) != (w < 0)) ? -p : p;
  endfunction

  function automatic int refNeuron(input int a, input int b, input int c);
    int s;
    s = refMul(a, 48) + refMul(b, -20) + refMul(c, 36) + 4;
    if (s > 127)  return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  // Presents one valid sample, then drops valid and drives filler inputs.
  // Returns just after the edge where that sample reaches y.
  task automatic applyStimulus(input logic signed [7:0] a, input logic signed [7:0] b,
                               input logic signed [7:0] c);
    @(negedge clk);
    x1 = a; x2 = b; x3 = c; in_valid = 1'b1;
    @(negedge clk);
    x1 = 8'sd99; x2 = -8'sd77; x3 = 8'sd55; in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [7:0] expY,
                             input logic expV);
    assertions++;
    assert (y === expY) else begin
      failures++;
      $error("[TB] FAIL %s: y observed %0d expected %0d", tag, y, expY);
    end
    assertions++;
    assert (out_valid === expV) else begin
      failures++;
      $error("[TB] FAIL %s: out_valid observed %0b expected %0b", tag, out_valid, expV);
    end
  endtask

  logic signed [7:0] rx1 [10];
  logic signed [7:0] rx2 [10];
  logic signed [7:0] rx3 [10];
  int                expRand [10];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; x1 = '0; x2 = '0; x3 = '0;
    #2;
    checkOutput("reset", 8'sd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    applyStimulus(8'sd0, 8'sd0, 8'sd0);
    checkOutput("bias_only", 8'sd4, 1'b1);
    applyStimulus(8'sd1, 8'sd1, 8'sd1);
    checkOutput("ones", 8'sd68, 1'b1);
    @(posedge clk); #1;
    checkOutput("hold_after_ones", 8'sd68, 1'b0);
    applyStimulus(-8'sd1, -8'sd1, -8'sd1);
    checkOutput("minus_ones", -8'sd60, 1'b1);
    applyStimulus(8'sd2, 8'sd0, 8'sd2);
    checkOutput("pos_sat", 8'sd127, 1'b1);
    applyStimulus(-8'sd4, 8'sd0, 8'sd0);
    checkOutput("neg_sat", -8'sd128, 1'b1);
    applyStimulus(8'sd3, 8'sd0, -8'sd1);
    checkOutput("mitchell_3x48", 8'sd96, 1'b1);
    applyStimulus(8'sd0, 8'sd5, 8'sd0);
    checkOutput("mitchell_5x-20", -8'sd92, 1'b1);
    applyStimulus(-8'sd128, 8'sd0, 8'sd0);
    checkOutput("min_input", -8'sd128, 1'b1);

    $display("[TB] back-to-back random samples");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 10) begin
        rx1[i] = 8'($urandom);
        rx2[i] = 8'($urandom);
        rx3[i] = 8'($urandom_range(0, 15)) - 8'sd8;
        expRand[i] = refNeuron(int'(rx1[i]), int'(rx2[i]), int'(rx3[i]));
        x1 = rx1[i]; x2 = rx2[i]; x3 = rx3[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i >= 1 && i <= 10) checkOutput("rand_stream", 8'(expRand[i - 1]), 1'b1);
      if (i == 11)           checkOutput("rand_tail_hold", 8'(expRand[9]), 1'b0);
    end

    $display("[TB] reset mid-stream");
    @(negedge clk);
    x1 = 8'sd1; x2 = 8'sd1; x3 = 8'sd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x1 = 8'sd2; x2 = 8'sd0; x3 = 8'sd2;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'sd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_reset_flush1", 8'sd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("post_reset_flush2", 8'sd0, 1'b0);
    applyStimulus(8'sd3, 8'sd0, -8'sd1);
    checkOutput("post_reset_sample", 8'sd96, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
